// File: rtl/instr_fetch_unit_if.sv
// Bundle of the PC-in, byte-memory and decode-side signals of the fetch stage.
// slave is the fetch unit's view; master is the view of whatever surrounds it.
interface instr_fetch_unit_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        fetch_err;

    modport slave (
        input  pc_in, pc_valid, mem_rdata, mem_ack, instr_ready, flush,
        output pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_err
    );

    modport master (
        output pc_in, pc_valid, mem_rdata, mem_ack, instr_ready, flush,
        input  pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch: reads four bytes big-endian over a req/ack byte bus and
// hands the assembled word to decode over valid/ready, with flush and timeout.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    instr_fetch_unit_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int unsigned   TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TCNT_LAST  = TIMEOUT_EN ? TW'(TIMEOUT_CYCLES - 1) : {TW{1'b0}};

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   instr_pc_q, instr_pc_d;
    logic          instr_valid_q, instr_valid_d;
    logic          fetch_err_q, fetch_err_d;

    logic pc_ready_s;
    logic accept_s;
    logic misalign_s;

    // Byte idx lands in the big-endian lane: idx 0 -> [31:24], idx 3 -> [7:0].
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[31:24] = data;
            2'd1:    res[23:16] = data;
            2'd2:    res[15:8]  = data;
            2'd3:    res[7:0]   = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    // Acceptance handshake towards the PC logic.
    always_comb begin
        pc_ready_s = !bus.flush &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.instr_ready));
        accept_s   = bus.pc_valid && pc_ready_s;
        misalign_s = (bus.pc_in[1:0] != 2'b00);
    end

    // Next-state logic: flush overrides everything, then per-state work, then accept.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tcnt_d        = tcnt_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = 1'b0;

        if (bus.flush) begin
            state_d       = ST_IDLE;
            mem_req_d     = 1'b0;
            instr_valid_d = 1'b0;
            idx_d         = 2'd0;
            tcnt_d        = {TW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_FETCH: begin
                    if (bus.mem_ack) begin
                        instr_d = put_byte(instr_q, idx_q, bus.mem_rdata);
                        tcnt_d  = {TW{1'b0}};
                        if (idx_q == 2'd3) begin
                            mem_req_d     = 1'b0;
                            instr_valid_d = 1'b1;
                            state_d       = ST_HOLD;
                        end else begin
                            idx_d      = idx_q + 2'd1;
                            mem_addr_d = mem_addr_q + 32'd1;
                        end
                    end else if (TIMEOUT_EN && (tcnt_q == TCNT_LAST)) begin
                        // Give up on a silent memory; the partial word is simply abandoned.
                        fetch_err_d = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = ST_IDLE;
                        idx_d       = 2'd0;
                        tcnt_d      = {TW{1'b0}};
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b0;
                    idx_d         = 2'd0;
                    tcnt_d        = {TW{1'b0}};
                end
            endcase

            // Accept is only possible from IDLE or a draining HOLD, so it may override them.
            if (accept_s) begin
                if (misalign_s) begin
                    fetch_err_d = 1'b1;
                    state_d     = ST_IDLE;
                    mem_req_d   = 1'b0;
                end else begin
                    instr_pc_d = bus.pc_in;
                    mem_addr_d = bus.pc_in;
                    mem_req_d  = 1'b1;
                    idx_d      = 2'd0;
                    tcnt_d     = {TW{1'b0}};
                    state_d    = ST_FETCH;
                end
            end else begin
                fetch_err_d = fetch_err_d;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= 2'd0;
            tcnt_q        <= {TW{1'b0}};
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'd0;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tcnt_q        <= tcnt_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign bus.pc_ready    = pc_ready_s;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a transaction-level model checked every
// negedge, plus literal expectations at the key cycles of each scenario.
module tb_instr_fetch_unit;

    localparam int TMO = 16;

    logic clock = 1'b0;
    logic reset_n;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [0:255];
    int         ack_mode  = 0;
    logic       alt_phase = 1'b0;

    // Model: a fetch in flight collects bytes into a list, a held word waits for decode.
    bit          m_fetching = 1'b0;
    bit          m_holding  = 1'b0;
    bit          m_err      = 1'b0;
    bit          m_acc      = 1'b0;
    int          m_got      = 0;
    int          m_wait     = 0;
    logic [31:0] m_pc       = 32'd0;
    logic [31:0] m_word     = 32'd0;
    logic [7:0]  m_bytes [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %08h required %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_pc_ready();
        return !bus.flush && ((!m_fetching && !m_holding) || (m_holding && bus.instr_ready));
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_fetching = 1'b0;
            m_holding  = 1'b0;
            m_err      = 1'b0;
            m_got      = 0;
            m_wait     = 0;
        end else begin
            m_acc = bus.pc_valid && exp_pc_ready();
            m_err = 1'b0;
            if (bus.flush) begin
                m_fetching = 1'b0;
                m_holding  = 1'b0;
                m_got      = 0;
                m_wait     = 0;
            end else begin
                if (m_fetching) begin
                    if (bus.mem_ack) begin
                        m_bytes[m_got] = bus.mem_rdata;
                        m_got++;
                        m_wait = 0;
                        if (m_got == 4) begin
                            m_fetching = 1'b0;
                            m_holding  = 1'b1;
                            m_word     = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                        end
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin
                            m_err      = 1'b1;
                            m_fetching = 1'b0;
                        end
                    end
                end else if (m_holding && bus.instr_ready) begin
                    m_holding = 1'b0;
                end
                if (m_acc) begin
                    if (bus.pc_in[1:0] != 2'b00) begin
                        m_err = 1'b1;
                    end else begin
                        m_fetching = 1'b1;
                        m_holding  = 1'b0;
                        m_pc       = bus.pc_in;
                        m_got      = 0;
                        m_wait     = 0;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        chk1("pc_ready", bus.pc_ready, exp_pc_ready());
        chk1("mem_req", bus.mem_req, m_fetching);
        chk1("instr_valid", bus.instr_valid, m_holding);
        chk1("fetch_err", bus.fetch_err, m_err);
        if (m_fetching) chk("mem_addr", bus.mem_addr, m_pc + 32'(m_got));
        if (m_holding) begin
            chk("instr", bus.instr, m_word);
            chk("instr_pc", bus.instr_pc, m_pc);
        end
    end

    // Advance one cycle and drive the memory side for the new cycle.
    task automatic step();
        @(posedge clock);
        #1;
        case (ack_mode)
            0:       bus.mem_ack = 1'b0;
            1:       bus.mem_ack = 1'b1;
            2: begin
                bus.mem_ack = alt_phase;
                alt_phase   = !alt_phase;
            end
            default: bus.mem_ack = 1'b0;
        endcase
        bus.mem_rdata = bus.mem_ack ? mem[bus.mem_addr[7:0]] : 8'hA5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        bus.pc_in       = 32'd0;
        bus.pc_valid    = 1'b0;
        bus.mem_rdata   = 8'd0;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b0;
        bus.flush       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0]  = 8'h20; mem[1]  = 8'h01; mem[2]  = 8'h00; mem[3]  = 8'h05;
        mem[4]  = 8'h11; mem[5]  = 8'h22; mem[6]  = 8'h33; mem[7]  = 8'h44;
        mem[28] = 8'h20; mem[29] = 8'h04; mem[30] = 8'h00; mem[31] = 8'h01;

        #2;
        chk1("rst_pc_ready", bus.pc_ready, 1'b1);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, 32'd0);
        chk1("rst_instr_valid", bus.instr_valid, 1'b0);
        chk1("rst_fetch_err", bus.fetch_err, 1'b0);
        step();
        step();
        reset_n = 1'b1;

        // Back-to-back acks from pc 0.
        step();
        bus.pc_valid = 1'b1; bus.pc_in = 32'd0; ack_mode = 1;
        for (int c = 1; c <= 4; c++) begin
            step();
            bus.pc_valid = 1'b0;
            chk1("t1_req", bus.mem_req, 1'b1);
            chk("t1_addr", bus.mem_addr, 32'(c - 1));
            chk1("t1_valid_early", bus.instr_valid, 1'b0);
        end
        step();
        chk1("t1_valid", bus.instr_valid, 1'b1);
        chk("t1_instr", bus.instr, 32'h20010005);
        chk("t1_pc", bus.instr_pc, 32'd0);
        bus.instr_ready = 1'b1; ack_mode = 0;
        step();
        bus.instr_ready = 1'b0;
        chk1("t1_consumed", bus.instr_valid, 1'b0);

        // Acks on alternate cycles only.
        bus.pc_valid = 1'b1; bus.pc_in = 32'd0; ack_mode = 2; alt_phase = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            bus.pc_valid = 1'b0;
            chk("t2_addr", bus.mem_addr, 32'((c - 1) / 2));
            chk1("t2_valid_early", bus.instr_valid, 1'b0);
        end
        step();
        ack_mode = 0;
        chk1("t2_valid", bus.instr_valid, 1'b1);
        chk("t2_instr", bus.instr, 32'h20010005);

        // Decode stalls for 10 cycles, then takes the word while a new pc arrives.
        for (int c = 0; c < 10; c++) begin
            step();
            chk("hold_instr", bus.instr, 32'h20010005);
            chk1("hold_valid", bus.instr_valid, 1'b1);
            chk1("hold_pc_ready", bus.pc_ready, 1'b0);
        end
        bus.instr_ready = 1'b1; bus.pc_valid = 1'b1; bus.pc_in = 32'd4; ack_mode = 1;
        #1;
        chk1("b2b_pc_ready", bus.pc_ready, 1'b1);
        step();
        bus.instr_ready = 1'b0; bus.pc_valid = 1'b0;
        chk("b2b_addr", bus.mem_addr, 32'd4);
        chk1("b2b_req", bus.mem_req, 1'b1);
        chk1("b2b_valid", bus.instr_valid, 1'b0);
        repeat (4) step();
        chk1("b2b_done", bus.instr_valid, 1'b1);
        chk("b2b_instr", bus.instr, 32'h11223344);
        chk("b2b_pc", bus.instr_pc, 32'd4);
        bus.instr_ready = 1'b1; ack_mode = 0;
        step();
        bus.instr_ready = 1'b0;

        // Misaligned pc.
        bus.pc_valid = 1'b1; bus.pc_in = 32'h6;
        step();
        bus.pc_valid = 1'b0;
        chk1("mis_err", bus.fetch_err, 1'b1);
        chk1("mis_req", bus.mem_req, 1'b0);
        chk1("mis_pc_ready", bus.pc_ready, 1'b1);
        step();
        chk1("mis_err_once", bus.fetch_err, 1'b0);
        chk1("mis_req_after", bus.mem_req, 1'b0);

        // Memory never acks.
        bus.pc_valid = 1'b1; bus.pc_in = 32'h40;
        step();
        bus.pc_valid = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            chk1("tmo_req", bus.mem_req, 1'b1);
            chk1("tmo_err_early", bus.fetch_err, 1'b0);
            step();
        end
        chk1("tmo_err", bus.fetch_err, 1'b1);
        chk1("tmo_req_drop", bus.mem_req, 1'b0);
        chk1("tmo_valid", bus.instr_valid, 1'b0);
        step();
        chk1("tmo_err_once", bus.fetch_err, 1'b0);
        chk1("tmo_idle", bus.pc_ready, 1'b1);

        // Flush after two bytes; a pc offered during flush waits a cycle.
        bus.pc_valid = 1'b1; bus.pc_in = 32'd0; ack_mode = 1;
        step();
        bus.pc_valid = 1'b0;
        step();
        step();
        bus.flush = 1'b1; bus.pc_valid = 1'b1; bus.pc_in = 32'h1C;
        #1;
        chk1("fl_pc_ready", bus.pc_ready, 1'b0);
        step();
        bus.flush = 1'b0;
        chk1("fl_req", bus.mem_req, 1'b0);
        chk1("fl_valid", bus.instr_valid, 1'b0);
        chk1("fl_err", bus.fetch_err, 1'b0);
        step();
        bus.pc_valid = 1'b0;
        chk1("fl_refetch_req", bus.mem_req, 1'b1);
        chk("fl_refetch_addr", bus.mem_addr, 32'h1C);
        repeat (3) step();
        step();
        chk1("fl_valid2", bus.instr_valid, 1'b1);
        chk("fl_instr", bus.instr, 32'h20040001);
        chk("fl_pc", bus.instr_pc, 32'h1C);
        bus.instr_ready = 1'b1; ack_mode = 0;
        step();
        bus.instr_ready = 1'b0;

        // Asynchronous reset in the middle of a fetch.
        bus.pc_valid = 1'b1; bus.pc_in = 32'd0; ack_mode = 1;
        step();
        bus.pc_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk1("ar_req", bus.mem_req, 1'b0);
        chk1("ar_valid", bus.instr_valid, 1'b0);
        chk1("ar_err", bus.fetch_err, 1'b0);
        chk("ar_addr", bus.mem_addr, 32'd0);
        chk1("ar_pc_ready", bus.pc_ready, 1'b1);
        step();
        reset_n = 1'b1;
        bus.pc_valid = 1'b1; bus.pc_in = 32'd4;
        step();
        bus.pc_valid = 1'b0;
        repeat (3) step();
        step();
        chk1("ar_fresh_valid", bus.instr_valid, 1'b1);
        chk("ar_fresh_instr", bus.instr, 32'h11223344);
        bus.instr_ready = 1'b1; ack_mode = 0;
        step();
        bus.instr_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
